// File: rtl/mem_bus_router.sv
// ------------------------------------------------------------------------
// mem_bus_router: decodes CPU address into NREG device regions and runs the
// CPU handshake; optional bus timeout enabled by ROUTER_TIMEOUT_EN. Rev 1.0
// ------------------------------------------------------------------------
`default_nettype none

module mem_bus_router #(
  parameter int unsigned          NREG    = 4,
  parameter int unsigned          AW      = 16,
  parameter int unsigned          DW      = 16,
  parameter logic [NREG*AW-1:0]   BASES   = {16'hFFFF, 16'h4C00, 16'h1000, 16'h0001},
  parameter int unsigned          TIMEOUT = 255
) (
  input  logic                 cpu_clk,
  input  logic                 rst,
  input  logic [AW-1:0]        addr,
  input  logic [DW-1:0]        wdata,
  input  logic                 read,
  input  logic                 write,
  output logic [DW-1:0]        rdata,
  output logic                 busy,
  output logic                 ready,
  output logic                 err,
  input  logic                 err_clr,
  output logic [AW-1:0]        dev_addr,
  output logic [DW-1:0]        dev_wdata,
  output logic [NREG-1:0]      dev_read,
  output logic [NREG-1:0]      dev_write,
  input  logic [NREG*DW-1:0]   dev_rdata,
  input  logic [NREG-1:0]      dev_ready
);

  localparam int unsigned RW = (NREG > 1) ? $clog2(NREG) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [RW-1:0]   region_q, region_d;
  logic            wr_q, wr_d;
  logic [AW-1:0]   dev_addr_q, dev_addr_d;
  logic [DW-1:0]   dev_wdata_q, dev_wdata_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic            err_q, err_d;
  logic            w_err_set;

  logic            w_mapped;
  logic [RW-1:0]   w_region;
  logic [AW-1:0]   w_base;
  logic [NREG-1:0] w_sel_oh;

`ifdef ROUTER_TIMEOUT_EN
  localparam logic [7:0] TO_LIM = 8'(TIMEOUT);
  logic [7:0]      cnt_q, cnt_d;
`else
  logic            unused_timeout;
  assign unused_timeout = ^TIMEOUT;
`endif

  // Bases ascend, so the last matching region is the highest one.
  always_comb begin
    w_mapped = 1'b0;
    w_region = '0;
    w_base   = '0;
    for (int i = 0; i < NREG; i++) begin
      if (addr >= BASES[i*AW +: AW]) begin
        w_mapped = 1'b1;
        w_region = RW'(i);
        w_base   = BASES[i*AW +: AW];
      end
    end
  end

  assign w_sel_oh = NREG'(1) << region_q;

  always_comb begin
    state_d     = state_q;
    region_d    = region_q;
    wr_d        = wr_q;
    dev_addr_d  = dev_addr_q;
    dev_wdata_d = dev_wdata_q;
    rdata_d     = rdata_q;
    w_err_set   = 1'b0;
`ifdef ROUTER_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (read || write) begin
          region_d    = w_region;
          wr_d        = write;
          dev_addr_d  = addr - w_base;
          dev_wdata_d = wdata;
          rdata_d     = '0;
`ifdef ROUTER_TIMEOUT_EN
          cnt_d       = '0;
`endif
          if (w_mapped) begin
            state_d = S_ACC;
          end else begin
            state_d   = S_RESP;
            w_err_set = 1'b1;
          end
        end
      end
      S_ACC: begin
`ifdef ROUTER_TIMEOUT_EN
        cnt_d = cnt_q + 8'd1;
`endif
        if (dev_ready[region_q]) begin
          rdata_d = wr_q ? '0 : dev_rdata[region_q*DW +: DW];
          state_d = S_RESP;
        end
`ifdef ROUTER_TIMEOUT_EN
        else if (cnt_d == TO_LIM) begin
          rdata_d   = '0;
          state_d   = S_RESP;
          w_err_set = 1'b1;
        end
`endif
      end
      S_RESP: begin
        if (!read && !write) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A new error outranks a simultaneous clear request.
  always_comb begin
    err_d = err_q;
    if (err_clr) err_d = 1'b0;
    if (w_err_set) err_d = 1'b1;
  end

  always_ff @(posedge cpu_clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      region_q    <= '0;
      wr_q        <= 1'b0;
      dev_addr_q  <= '0;
      dev_wdata_q <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
`ifdef ROUTER_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      region_q    <= region_d;
      wr_q        <= wr_d;
      dev_addr_q  <= dev_addr_d;
      dev_wdata_q <= dev_wdata_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
`ifdef ROUTER_TIMEOUT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign rdata     = rdata_q;
  assign busy      = (state_q == S_ACC);
  assign ready     = (state_q == S_RESP);
  assign err       = err_q;
  assign dev_addr  = dev_addr_q;
  assign dev_wdata = dev_wdata_q;
  assign dev_read  = ((state_q == S_ACC) && !wr_q) ? w_sel_oh : '0;
  assign dev_write = ((state_q == S_ACC) &&  wr_q) ? w_sel_oh : '0;

endmodule

`default_nettype wire
